// File: rtl/w_stage_grf.sv
// W-stage writeback: load-data extraction, 32x32 GRF with same-cycle W-to-D
// bypass, W forwarding value, retired-write counter and sticky Tnew error.
module w_stage_grf #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       W_A3,
  input  logic [31:0]      W_PC,
  input  logic [31:0]      W_Reg_Data,
  input  logic [1:0]       W_Addr_Low,
  input  logic             W_Reg_Write,
  input  logic             W_Is_New,
  input  logic [1:0]       W_width,
  input  logic             W_Ext_Sign,
  input  logic [3:0]       W_Tnew,
  input  logic [4:0]       D_rs_addr,
  input  logic [4:0]       D_rt_addr,
  output logic [31:0]      D_rs_data,
  output logic [31:0]      D_rt_data,
  output logic [31:0]      W_Fwd_Data,
  output logic             W_Fwd_Valid,
  output logic [CNT_W-1:0] Wr_Count,
  output logic             Tnew_Err,
  output logic [31:0]      Trace_PC,
  output logic [4:0]       Trace_A3,
  output logic [31:0]      Trace_Data
);

  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;

  logic [31:0] grf [NREG];
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        commit;

  // Load-data extraction; reserved width behaves as word
  always_comb begin
    half_sel = W_Addr_Low[1] ? W_Reg_Data[31:16] : W_Reg_Data[15:0];
    case (W_Addr_Low)
      2'd0:    byte_sel = W_Reg_Data[7:0];
      2'd1:    byte_sel = W_Reg_Data[15:8];
      2'd2:    byte_sel = W_Reg_Data[23:16];
      default: byte_sel = W_Reg_Data[31:24];
    endcase
    W_Fwd_Data = W_Reg_Data;
    if (W_Is_New) begin
      case (W_width)
        WIDTH_HALF: W_Fwd_Data = {{16{W_Ext_Sign & half_sel[15]}}, half_sel};
        WIDTH_BYTE: W_Fwd_Data = {{24{W_Ext_Sign & byte_sel[7]}}, byte_sel};
        default:    W_Fwd_Data = W_Reg_Data;
      endcase
    end
  end

  assign W_Fwd_Valid = W_Reg_Write & (W_A3 != 5'd0) & (W_Tnew == 4'd0);
  assign commit      = W_Fwd_Valid;

  // Read ports: r0 hard-wired to zero, then bypass of the committing write
  always_comb begin
    D_rs_data = grf[D_rs_addr];
    if (D_rs_addr == 5'd0)
      D_rs_data = 32'd0;
    else if (commit && (D_rs_addr == W_A3))
      D_rs_data = W_Fwd_Data;
  end

  always_comb begin
    D_rt_data = grf[D_rt_addr];
    if (D_rt_addr == 5'd0)
      D_rt_data = 32'd0;
    else if (commit && (D_rt_addr == W_A3))
      D_rt_data = W_Fwd_Data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) grf[i] <= 32'd0;
      Wr_Count   <= '0;
      Tnew_Err   <= 1'b0;
      Trace_PC   <= 32'd0;
      Trace_A3   <= 5'd0;
      Trace_Data <= 32'd0;
    end else begin
      if (commit) begin
        grf[W_A3]  <= W_Fwd_Data;
        Wr_Count   <= Wr_Count + CNT_W'(1);
        Trace_PC   <= W_PC;
        Trace_A3   <= W_A3;
        Trace_Data <= W_Fwd_Data;
      end
      if (W_Reg_Write && (W_Tnew != 4'd0))
        Tnew_Err <= 1'b1;
    end
  end

endmodule
